// File: rtl/udp_tx_framer.sv
// udp_tx_framer: prepends a one-word header (sync, sequence, length) to each
// frame of payload words and streams the result through a single output
// register stage. Frame length is captured when the header is emitted.
// Only DATA_WIDTH = 64 is meaningful because the header layout is 64 bits.
module udp_tx_framer #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 8
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  s_axis_ready,
    input  logic [LEN_W-1:0]      cfg_len_words,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic [31:0]           stat_frames
);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [15:0]           seq_q, seq_d;
    logic [31:0]           stat_q, stat_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;

    logic                  out_free;
    logic                  s_ready;
    logic [LEN_W-1:0]      len_new;
    logic [15:0]           len_field;
    logic [DATA_WIDTH-1:0] header_word;
    logic                  last_word;

    // A zero length request is treated as a one-word frame so every frame has payload.
    assign len_new     = (cfg_len_words == '0) ? LEN_W'(1) : cfg_len_words;
    assign len_field   = 16'(len_new);
    assign header_word = {16'hA5C3, seq_q, len_field, 16'h0000};
    assign last_word   = (count_q == (len_q - LEN_W'(1)));
    assign out_free    = !m_valid_q || m_axis_ready;

    // Next-state and output-register loading: header from IDLE, payload words in PAYLOAD.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        seq_d     = seq_q;
        stat_d    = stat_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        s_ready   = 1'b0;

        if (out_free) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_axis_valid && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = header_word;
                    m_last_d  = 1'b0;
                    len_d     = len_new;
                    count_d   = '0;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_ready = out_free;
                if (s_axis_valid && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_data;
                    m_last_d  = last_word;
                    if (last_word) begin
                        seq_d   = seq_q + 16'd1;
                        stat_d  = stat_q + 32'd1;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, frame bookkeeping and the output register; reset clears everything.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            stat_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            stat_q    <= stat_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_axis_ready = s_ready;
    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_last  = m_last_q;
    assign stat_frames  = stat_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: randomized and directed stimulus for udp_tx_framer,
// checked against a frame-level reference model (expected output stream
// built from the frame list: header then payload words per frame).
module tb_udp_tx_framer;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        s_axis_valid;
    logic [63:0] s_axis_data;
    logic        s_axis_ready;
    logic [7:0]  cfg_len_words;
    logic        m_axis_valid;
    logic [63:0] m_axis_data;
    logic        m_axis_last;
    logic        m_axis_ready;
    logic [31:0] stat_frames;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] in_q[$];
    logic [63:0] exp_data_q[$];
    logic        exp_last_q[$];
    logic [15:0] seq_m;
    logic [31:0] frames_m;

    bit          in_fire;
    int          fires;
    int          first_fire_cyc;
    int          last_fire_cyc;
    bit          stall_prev;
    logic [63:0] stall_data;
    logic        stall_last;

    udp_tx_framer #(
        .DATA_WIDTH(64),
        .LEN_W(8)
    ) dut (
        .axis_clk(axis_clk),
        .axis_rst(axis_rst),
        .s_axis_valid(s_axis_valid),
        .s_axis_data(s_axis_data),
        .s_axis_ready(s_axis_ready),
        .cfg_len_words(cfg_len_words),
        .m_axis_valid(m_axis_valid),
        .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last),
        .m_axis_ready(m_axis_ready),
        .stat_frames(stat_frames)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 axis_clk = ~axis_clk;

    // Cycle counter used for latency and bubble measurements.
    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Mid-cycle monitor: scoreboard on output handshakes, stall stability, input handshake flag.
    always @(negedge axis_clk) begin
        logic [63:0] exp_d;
        logic        exp_l;
        if (axis_rst) begin
            stall_prev = 1'b0;
            in_fire    = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("stall_valid", 64'(m_axis_valid), 64'd1);
                checkOutput("stall_data", m_axis_data, stall_data);
                checkOutput("stall_last", 64'(m_axis_last), 64'(stall_last));
            end
            if (m_axis_valid && !m_axis_ready) begin
                checkOutput("stall_s_ready", 64'(s_axis_ready), 64'd0);
                stall_prev = 1'b1;
                stall_data = m_axis_data;
                stall_last = m_axis_last;
            end else begin
                stall_prev = 1'b0;
            end
            if (m_axis_valid && m_axis_ready) begin
                checkOutput("word_expected", 64'(exp_data_q.size() != 0), 64'd1);
                if (exp_data_q.size() != 0) begin
                    exp_d = exp_data_q.pop_front();
                    exp_l = exp_last_q.pop_front();
                    checkOutput("out_data", m_axis_data, exp_d);
                    checkOutput("out_last", 64'(m_axis_last), 64'(exp_l));
                end
                if (fires == 0) first_fire_cyc = cyc;
                last_fire_cyc = cyc;
                fires++;
            end
            in_fire = s_axis_valid && s_axis_ready;
        end
    end

    // Reset pulse starting mid-cycle; outputs are checked before any clock edge.
    task automatic pulseReset();
        axis_rst     = 1'b1;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        #1;
        checkOutput("rst_m_valid", 64'(m_axis_valid), 64'd0);
        checkOutput("rst_m_last", 64'(m_axis_last), 64'd0);
        checkOutput("rst_m_data", m_axis_data, 64'd0);
        checkOutput("rst_s_ready", 64'(s_axis_ready), 64'd0);
        checkOutput("rst_stat", 64'(stat_frames), 64'd0);
        in_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        seq_m    = 16'd0;
        frames_m = 32'd0;
        repeat (2) @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
    endtask

    // Builds the expected stream for nframes frames, then drives them with random gaps and backpressure.
    task automatic applyStimulus(input int nframes, input int cfg, input int valid_pct, input int ready_pct,
                                 input bit cfg_wiggle, input bit stall5, input int abort_after);
        int          len;
        int          pos;
        int          consumed;
        int          stall_left;
        bit          stalled_once;
        bit          aborted;
        int          start_cyc;
        int          budget;
        int          words_total;
        logic [63:0] word;

        len = (cfg == 0) ? 1 : cfg;
        for (int f = 0; f < nframes; f++) begin
            exp_data_q.push_back({16'hA5C3, seq_m, 16'(len), 16'h0000});
            exp_last_q.push_back(1'b0);
            for (int w = 0; w < len; w++) begin
                word = {$urandom(), $urandom()};
                in_q.push_back(word);
                exp_data_q.push_back(word);
                exp_last_q.push_back(w == len - 1);
            end
            seq_m    = seq_m + 16'd1;
            frames_m = frames_m + 32'd1;
        end

        words_total    = nframes * (len + 1);
        budget         = words_total * 40 + 100;
        fires          = 0;
        first_fire_cyc = -1;
        last_fire_cyc  = -1;
        pos            = 0;
        consumed       = 0;
        stall_left     = 0;
        stalled_once   = 1'b0;
        aborted        = 1'b0;
        start_cyc      = cyc;

        for (int c = 0; c < budget; c++) begin
            if (stall5 && !stalled_once && pos == 1) begin
                stall_left   = 5;
                stalled_once = 1'b1;
            end
            s_axis_valid = (in_q.size() != 0) && ($urandom_range(99) < valid_pct);
            s_axis_data  = (in_q.size() != 0) ? in_q[0] : 64'h0;
            if (stall_left > 0) begin
                m_axis_ready = 1'b0;
                stall_left--;
            end else begin
                m_axis_ready = ($urandom_range(99) < ready_pct);
            end
            cfg_len_words = (cfg_wiggle && pos > 0) ? 8'($urandom()) : 8'(cfg);
            @(posedge axis_clk);
            #1;
            if (in_fire) begin
                void'(in_q.pop_front());
                consumed++;
                pos = (pos + 1 == len) ? 0 : pos + 1;
            end
            if (abort_after > 0 && consumed == abort_after) begin
                aborted = 1'b1;
                break;
            end
            if (in_q.size() == 0 && exp_data_q.size() == 0) break;
        end
        s_axis_valid  = 1'b0;
        m_axis_ready  = 1'b1;
        cfg_len_words = 8'(cfg);

        if (!aborted) begin
            checkOutput("drained", 64'(exp_data_q.size()), 64'd0);
            checkOutput("stat_frames", 64'(stat_frames), 64'(frames_m));
            if (valid_pct == 100 && ready_pct == 100 && !stall5) begin
                checkOutput("header_latency", 64'(first_fire_cyc - start_cyc), 64'd1);
                checkOutput("no_bubble", 64'(last_fire_cyc - first_fire_cyc + 1), 64'(words_total));
            end
        end
    endtask

    // Test sequence: directed frame scenarios, random traffic, reset mid-frame, sequence wrap.
    initial begin
        axis_rst      = 1'b1;
        s_axis_valid  = 1'b0;
        s_axis_data   = 64'h0;
        cfg_len_words = 8'd0;
        m_axis_ready  = 1'b1;
        seq_m         = 16'd0;
        frames_m      = 32'd0;
        fires         = 0;
        in_fire       = 1'b0;
        stall_prev    = 1'b0;

        pulseReset();
        $display("[TB] single frame len=3");
        applyStimulus(1, 3, 100, 100, 1'b0, 1'b0, 0);

        pulseReset();
        $display("[TB] back-to-back frames len=2");
        applyStimulus(2, 2, 100, 100, 1'b0, 1'b0, 0);

        $display("[TB] 5-cycle backpressure mid-payload");
        applyStimulus(1, 4, 100, 100, 1'b0, 1'b1, 0);

        $display("[TB] zero length request");
        applyStimulus(2, 0, 100, 100, 1'b0, 1'b0, 0);

        $display("[TB] cfg changes during payload");
        applyStimulus(4, 3, 80, 70, 1'b1, 1'b0, 0);

        $display("[TB] random traffic");
        for (int t = 0; t < 8; t++) begin
            applyStimulus(1 + $urandom_range(3), $urandom_range(6), 50 + $urandom_range(49),
                          40 + $urandom_range(59), 1'b0, 1'b0, 0);
        end

        $display("[TB] reset after 2 of 4 payload words");
        applyStimulus(1, 4, 100, 100, 1'b0, 1'b0, 2);
        pulseReset();
        checkOutput("stat_after_reset", 64'(stat_frames), 64'd0);
        applyStimulus(1, 2, 100, 100, 1'b0, 1'b0, 0);

        $display("[TB] sequence wrap after 65536 frames");
        pulseReset();
        applyStimulus(65536, 1, 100, 100, 1'b0, 1'b0, 0);
        applyStimulus(1, 1, 100, 100, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_tx_framer.md
UDP_TX_FRAMER -- requirements
Module: udp_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, giving the payload and output word width; legal value is 64 only.
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the width of the frame-length configuration input.
REQ-003 The block SHALL have port axis_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port axis_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port s_axis_valid, input, 1 bit: a payload word is present from the upstream word FIFO.
REQ-006 The block SHALL have port s_axis_data, input, DATA_WIDTH bits: the payload word.
REQ-007 The block SHALL have port s_axis_ready, output, 1 bit: the payload word is accepted this cycle.
REQ-008 The block SHALL have port cfg_len_words, input, LEN_W bits: payload words per frame, sampled at frame start.
REQ-009 The block SHALL have port m_axis_valid, output, 1 bit: an output word is valid.
REQ-010 The block SHALL have port m_axis_data, output, DATA_WIDTH bits: the output word (header or payload).
REQ-011 The block SHALL have port m_axis_last, output, 1 bit: this word is the final word of a frame.
REQ-012 The block SHALL have port m_axis_ready, input, 1 bit: downstream accepts the output word.
REQ-013 The block SHALL have port stat_frames, output, 32 bits: count of completed frames, wrapping modulo 2^32.

Function
REQ-014 All outputs SHALL be driven from one output register stage; out_free = !m_axis_valid || m_axis_ready.
REQ-015 The FSM SHALL have two states, IDLE and PAYLOAD, and SHALL reset to IDLE.
REQ-016 In IDLE, s_axis_ready SHALL be 0 and no input word SHALL be consumed.
REQ-017 In IDLE, when s_axis_valid=1 and out_free=1, the block SHALL load a header word, latch len = (cfg_len_words==0 ? 1 : cfg_len_words), clear the word counter, and enter PAYLOAD.
REQ-018 The header word SHALL be: [63:48]=16'hA5C3, [47:32]=seq (16-bit frame sequence), [31:16]=len zero-extended, [15:0]=0; m_axis_last=0.
REQ-019 In PAYLOAD, s_axis_ready SHALL equal out_free; each accepted word SHALL be loaded unmodified into the output register on the same edge.
REQ-020 On the accepted word where count==len-1, the block SHALL set m_axis_last=1, increment seq (wrapping 0xFFFF->0x0000) and stat_frames, and return to IDLE.
REQ-021 While m_axis_valid=1 and m_axis_ready=0, m_axis_data and m_axis_last SHALL hold stable; m_axis_valid SHALL NOT deassert.
REQ-022 If out_free=1 and nothing is loaded this cycle, m_axis_valid SHALL go to 0 on the next edge.
REQ-023 Latency SHALL be one cycle from the IDLE cycle with s_axis_valid=1 to the header appearing on m_axis_valid; payload throughput SHALL be one word per cycle with m_axis_ready held at 1.
REQ-024 Back-to-back frames SHALL incur no bubble: the header of frame N+1 SHALL load in the cycle after the last word of frame N loads, provided s_axis_valid=1 and out_free=1.
REQ-025 Changes to cfg_len_words during PAYLOAD SHALL NOT affect the current frame.
REQ-026 s_axis_valid dropping mid-frame SHALL stall the frame without inserting a word or terminating it.

Reset
REQ-027 While axis_rst=1, the block SHALL force state=IDLE, m_axis_valid=0, m_axis_last=0, m_axis_data=0, s_axis_ready=0, seq=0, count=0 and stat_frames=0, independent of the clock.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL carry seq=0.

Verification
REQ-029 The bench SHALL check: cfg_len_words=3, 3 words D0..D2 offered, m_axis_ready=1 -> output H(seq=0,len=3), D0, D1, D2(last=1) on consecutive cycles, with stat_frames=1.
REQ-030 The bench SHALL check: two frames back-to-back, len=2 -> 6 consecutive valid cycles with no bubble; the second header carries seq=1.
REQ-031 The bench SHALL check: m_axis_ready held 0 for 5 cycles mid-payload -> data and last stable, s_axis_ready=0, no word lost or duplicated.
REQ-032 The bench SHALL check: cfg_len_words=0 -> header len field=1 and one payload word with last=1.
REQ-033 The bench SHALL check: seq preset by 65536 frames of len=1 -> the 65537th header carries seq=0x0000.
REQ-034 The bench SHALL check: axis_rst pulsed after 2 of 4 payload words -> all outputs 0 immediately, and the next frame header carries seq=0 with stat_frames=0 before it completes.
